emm_arbiter: RTL
================

Name: emm_arbiter

Overview:
- Parametrised external memory manager. Arbitrates NUM_PORTS Wishbone pipelined requesters (fetch, load/store, debug, ...) onto one Wishbone pipelined master port toward external memory.
- Supports reads and writes and round-robin fairness.
- At most one transaction is outstanding on the master port at a time.
- Successor to the fixed two-port read-only memory mux; sits between the core's requesters and the system bus.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8).
- TIMEOUT_CYCLES, 255, maximum master wait cycles before error (used only with EMM_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- s_wb_adr_i  in  NUM_PORTS*32  per-port address; port i occupies bits [32i+31:32i].
- s_wb_dat_i  in  NUM_PORTS*32  per-port write data.
- s_wb_dat_o  out  32  read data, shared by all ports; qualified by the port's ack.
- s_wb_we_i  in  NUM_PORTS  per-port write enable.
- s_wb_sel_i  in  NUM_PORTS*4  per-port byte select.
- s_wb_stb_i  in  NUM_PORTS  per-port strobe.
- s_wb_cyc_i  in  NUM_PORTS  per-port cycle.
- s_wb_ack_o  out  NUM_PORTS  per-port acknowledge.
- s_wb_err_o  out  NUM_PORTS  per-port error (timeout).
- s_wb_stall_o  out  NUM_PORTS  per-port stall.
- m_wb_adr_o  out  32  master address.
- m_wb_dat_o  out  32  master write data.
- m_wb_dat_i  in  32  master read data.
- m_wb_we_o  out  1  master write enable.
- m_wb_sel_o  out  4  master byte select.
- m_wb_stb_o  out  1  master strobe.
- m_wb_cyc_o  out  1  master cycle.
- m_wb_ack_i  in  1  master acknowledge.
- m_wb_stall_i  in  1  master stall.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, rr pointer=0.
  - All m_* outputs 0; s_wb_ack_o=0, s_wb_err_o=0, s_wb_dat_o=0.
  - s_wb_stall_o = all ones while rst_i is high.
- Request definition: port i requests when s_wb_stb_i[i] & s_wb_cyc_i[i].
- Arbitration, IDLE only, combinational:
  - Winner = first requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
  - s_wb_stall_o[winner]=0; every other port stalled.
  - In any non-IDLE state all stalls are 1.
- Accept in IDLE with a request present:
  - Latch winner's adr/dat/we/sel and the grant index.
  - rr pointer <= (winner+1) mod NUM_PORTS.
  - Go to REQUEST.
- REQUEST: m_cyc=1, m_stb=1, registered request driven on the master port.
  - m_wb_stall_i=1: hold REQUEST, outputs stable.
  - Otherwise go to WAIT.
- WAIT: m_cyc=1, m_stb=0.
  - On m_wb_ack_i: latch m_wb_dat_i and go to DONE.
- DONE: m_cyc=0; s_wb_ack_o[grant]=1 for exactly one cycle; s_wb_dat_o = latched data (zero for writes); next state IDLE.
- Latency, no memory stall, memory acks one cycle after accept:
  - Requester accepted at cycle N.
  - m_stb at N+1.
  - m_ack at N+2.
  - s_ack at N+3.
  - Earliest next accept at N+4.
- No requests in IDLE: pointer unchanged, master outputs 0.
- Granted port drops cyc before DONE: master transaction still completes; no ack or err is issued to that port.
- m_wb_ack_i outside WAIT: ignored.
- Async reset mid-transaction: master cyc/stb drop immediately and no slave response is produced.

Optional Feature:
- Macro: EMM_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQUEST and increments each cycle in REQUEST or WAIT.
  - When it reaches TIMEOUT_CYCLES without an accepted ack: m_cyc and m_stb drop, s_wb_err_o[grant]=1 for one cycle (no ack), return to IDLE.
  - An m_ack arriving in the same cycle as the timeout wins: normal DONE.
- Undefined: no counter; WAIT lasts indefinitely; s_wb_err_o tied to 0.

Decomposition:
- ecap5_dproc_pkg:
  - emm_state_t enum {IDLE, REQUEST, WAIT, DONE}.
  - EMM_MAX_PORTS=8 constant.
- Sub-module emm_rr_arbiter:
  - Combinational winner and valid computation from request vector plus rr pointer.
  - Owns the pointer register, updated on a grant strobe.

Test Plan:
- NUM_PORTS=2; port0 read 0x0000_1000; memory returns 0xDEADBEEF one cycle after accept → s_ack[0] at N+3, s_dat_o=0xDEADBEEF, port1 stalled throughout.
- Both ports request continuously; 4 transactions → grants in order 0,1,0,1; each port sees exactly 2 acks.
- Port1 write adr 0x2000, dat 0x12345678, sel 0b0011; m_stall=1 for 3 cycles → m_stb held 4 cycles with stable adr/dat/sel/we=1; single s_ack[1].
- Async reset asserted in WAIT → m_cyc=0 immediately; no s_ack; next request after release is granted from port0 (pointer=0).
- EMM_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks → s_err[grant]=1 for one cycle after 8 cycles; m_cyc drops; next request served normally.
- NUM_PORTS=4, only port3 requests repeatedly → pointer wraps to 0; port3 granted every transaction with no idle gap beyond the 4-cycle minimum.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the external memory manager: FSM state encoding and port limits.
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT,
        DONE
    } emm_state_t;

    localparam int EMM_MAX_PORTS = 8;

endpackage

// File: rtl/emm_rr_arbiter.sv
// Round-robin winner selection over a request vector; owns the rotating priority pointer.
module emm_rr_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic                         grant_i,
    output logic [$clog2(NUM_PORTS)-1:0] winner_o,
    output logic                         valid_o
);
    localparam int IW = $clog2(NUM_PORTS);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan from the highest offset down so the port closest to the pointer is written last and wins.
    always_comb begin
        // NOTE: give every combinational output a default first so no path can infer a latch.
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % NUM_PORTS]) begin
                winner_o = IW'((int'(ptr_q) + k) % NUM_PORTS);
                valid_o  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_i) begin
            ptr_d = (int'(winner_o) == NUM_PORTS - 1) ? '0 : winner_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/emm_arbiter.sv
// External memory manager: round-robin arbitration of NUM_PORTS pipelined Wishbone requesters onto one master.
// Define EMM_TIMEOUT_EN to abort a master transaction with s_wb_err_o after TIMEOUT_CYCLES cycles.
module emm_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS*32-1:0] s_wb_adr_i,
    input  logic [NUM_PORTS*32-1:0] s_wb_dat_i,
    output logic [31:0]             s_wb_dat_o,
    input  logic [NUM_PORTS-1:0]    s_wb_we_i,
    input  logic [NUM_PORTS*4-1:0]  s_wb_sel_i,
    input  logic [NUM_PORTS-1:0]    s_wb_stb_i,
    input  logic [NUM_PORTS-1:0]    s_wb_cyc_i,
    output logic [NUM_PORTS-1:0]    s_wb_ack_o,
    output logic [NUM_PORTS-1:0]    s_wb_err_o,
    output logic [NUM_PORTS-1:0]    s_wb_stall_o,
    output logic [31:0]             m_wb_adr_o,
    output logic [31:0]             m_wb_dat_o,
    input  logic [31:0]             m_wb_dat_i,
    output logic                    m_wb_we_o,
    output logic [3:0]              m_wb_sel_o,
    output logic                    m_wb_stb_o,
    output logic                    m_wb_cyc_o,
    input  logic                    m_wb_ack_i,
    input  logic                    m_wb_stall_i
);
    localparam int IW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > EMM_MAX_PORTS) begin : g_bad_cfg
        $error("emm_arbiter: NUM_PORTS must be in 2..%0d", EMM_MAX_PORTS);
    end

    emm_state_t           state_q;
    logic [IW-1:0]        grant_q;
    logic [31:0]          adr_q;
    logic [31:0]          wdat_q;
    logic [31:0]          rdat_q;
    logic [3:0]           sel_q;
    logic                 we_q;
    logic                 cyc_q;
    logic                 stb_q;
    logic                 dropped_q;
    logic [NUM_PORTS-1:0] ack_q;
    logic [NUM_PORTS-1:0] err_q;

    logic [NUM_PORTS-1:0] req;
    logic [IW-1:0]        winner;
    logic                 winner_vld;
    logic                 accept;
    logic                 owner_live;
    logic                 timeout_hit;
    logic                 busy;

    assign req        = s_wb_stb_i & s_wb_cyc_i;
    assign accept     = (state_q == IDLE) && winner_vld;
    assign busy       = (state_q == REQUEST) || (state_q == WAIT);
    // A port that let go of cyc at any point during its transaction gets no response.
    assign owner_live = !dropped_q && s_wb_cyc_i[grant_q];

    emm_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req),
        .grant_i  (accept),
        .winner_o (winner),
        .valid_o  (winner_vld)
    );

`ifdef EMM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (accept) begin
            tmo_q <= '0;
        end else if (busy) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Fires in the cycle the counter steps onto TIMEOUT_CYCLES.
    assign timeout_hit = busy && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        s_wb_stall_o = '1;
        if (!rst_i && state_q == IDLE && winner_vld) begin
            s_wb_stall_o[winner] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            dropped_q <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
            ack_q <= '0;
            err_q <= '0;
            if (busy && !s_wb_cyc_i[grant_q]) begin
                dropped_q <= 1'b1;
            end

            // An ack landing in the timeout cycle still completes normally.
            if (timeout_hit && !(state_q == WAIT && m_wb_ack_i)) begin
                cyc_q          <= 1'b0;
                stb_q          <= 1'b0;
                adr_q          <= '0;
                wdat_q         <= '0;
                sel_q          <= '0;
                we_q           <= 1'b0;
                err_q[grant_q] <= owner_live;
                state_q        <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            grant_q   <= winner;
                            adr_q     <= s_wb_adr_i[32*int'(winner) +: 32];
                            wdat_q    <= s_wb_dat_i[32*int'(winner) +: 32];
                            sel_q     <= s_wb_sel_i[4*int'(winner) +: 4];
                            we_q      <= s_wb_we_i[winner];
                            cyc_q     <= 1'b1;
                            stb_q     <= 1'b1;
                            dropped_q <= 1'b0;
                            state_q   <= REQUEST;
                        end
                    end
                    REQUEST: begin
                        if (!m_wb_stall_i) begin
                            stb_q   <= 1'b0;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (m_wb_ack_i) begin
                            cyc_q          <= 1'b0;
                            rdat_q         <= we_q ? '0 : m_wb_dat_i;
                            ack_q[grant_q] <= owner_live;
                            state_q        <= DONE;
                        end
                    end
                    DONE: begin
                        adr_q   <= '0;
                        wdat_q  <= '0;
                        sel_q   <= '0;
                        we_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = wdat_q;
    assign m_wb_sel_o = sel_q;
    assign m_wb_we_o  = we_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = stb_q;
    assign s_wb_dat_o = rdat_q;
    assign s_wb_ack_o = ack_q;
    assign s_wb_err_o = err_q;

endmodule
